alu_regfile_ctrl: RTL

- Multi-cycle sequencer for the 16-bit datapath: 16x16 regfile (2 read ports, 1 write port) plus ALU with C/L/F/Z/N flag outputs.
- Accepts one register-register instruction per valid/ready handshake and drives the regfile read/write addresses, write enable and ALU operation code.
- Latches ALU flags into a 5-bit PSR.
- Also arbitrates the single regfile write port between instruction writeback and a host/debug preload port (bench or boot loader).

---
 rtl/alu_regfile_pkg.sv | 26 ++
 rtl/alu_regfile_ctrl_op_decode.sv | 46 ++++
 rtl/alu_regfile_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_regfile_pkg.sv
// alu_regfile_pkg: shared opcodes, ALU codes, FSM states and PSR layout for alu_regfile_ctrl
package alu_regfile_pkg;
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_CMP = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;
   localparam logic [3:0] OP_MOV = 4'd6;
   localparam logic [3:0] OP_LSH = 4'd7;
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_MOV = 3'd5;
   localparam logic [2:0] ALU_LSH = 3'd6;
   localparam int PSR_C = 0;
   localparam int PSR_L = 1;
   localparam int PSR_F = 2;
   localparam int PSR_Z = 3;
   localparam int PSR_N = 4;
   localparam logic [4:0] MASK_ARITH = 5'b00101;
   localparam logic [4:0] MASK_CMP   = 5'b11010;
   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;
endpackage

// File: rtl/alu_regfile_ctrl_op_decode.sv
// op_decode: maps an opcode to its ALU code, writeback enable, PSR update mask and illegal flag
//   op_i          instruction opcode
//   alu_op_o      ALU operation code (illegal opcodes drive ADD)
//   writes_rd_o   result is written back to rdest
//   flag_mask_o   PSR bits sampled at the end of EXEC, {N,Z,F,L,C}
//   illegal_o     opcode 8-15
module op_decode
   import alu_regfile_pkg::*;
#(
   parameter int OPW  = 4,
   parameter int ALUW = 3
) (
   input  logic [OPW-1:0]  op_i,
   output logic [ALUW-1:0] alu_op_o,
   output logic            writes_rd_o,
   output logic [4:0]      flag_mask_o,
   output logic            illegal_o
);
   always_comb begin
      alu_op_o    = ALU_ADD;
      writes_rd_o = 1'b1;
      flag_mask_o = '0;
      illegal_o   = 1'b0;
      case (op_i)
         OP_ADD: flag_mask_o = MASK_ARITH;
         OP_SUB: begin
            alu_op_o    = ALU_SUB;
            flag_mask_o = MASK_ARITH;
         end
         OP_CMP: begin
            alu_op_o    = ALU_SUB;
            flag_mask_o = MASK_CMP;
            writes_rd_o = 1'b0;
         end
         OP_AND: alu_op_o = ALU_AND;
         OP_OR:  alu_op_o = ALU_OR;
         OP_XOR: alu_op_o = ALU_XOR;
         OP_MOV: alu_op_o = ALU_MOV;
         OP_LSH: alu_op_o = ALU_LSH;
         default: begin
            illegal_o   = 1'b1;
            writes_rd_o = 1'b0;
         end
      endcase
   end
endmodule

// File: rtl/alu_regfile_ctrl.sv
// alu_regfile_ctrl: multi-cycle IDLE/READ/EXEC/WB sequencer for a 16x16 regfile + ALU, with host write arbitration
//   instr_*           valid/ready instruction port (op, rdest, rsrc)
//   host_we/host_wa   host preload request, granted combinationally in IDLE (host_grant)
//   ra1/ra2/wa        regfile addresses; regwrite/wd_sel write enable and data select (1 = host)
//   alu_op, alu_*     ALU operation code out, flags in; psr = {N,Z,F,L,C}
//   busy/done         instruction in flight / completion pulse
// Build option: CMP_SKIP_WB_EN lets CMP and illegal opcodes finish in EXEC.
module alu_regfile_ctrl
   import alu_regfile_pkg::*;
#(
   parameter int REG_AW = 4,
   parameter int OPW    = 4,
   parameter int ALUW   = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [OPW-1:0]    instr_op,
   input  logic [REG_AW-1:0] instr_rdest,
   input  logic [REG_AW-1:0] instr_rsrc,
   input  logic              host_we,
   input  logic [REG_AW-1:0] host_wa,
   output logic              host_grant,
   output logic [REG_AW-1:0] ra1,
   output logic [REG_AW-1:0] ra2,
   output logic [REG_AW-1:0] wa,
   output logic              regwrite,
   output logic              wd_sel,
   output logic [ALUW-1:0]   alu_op,
   input  logic              alu_c,
   input  logic              alu_l,
   input  logic              alu_f,
   input  logic              alu_z,
   input  logic              alu_n,
   output logic [4:0]        psr,
   output logic              busy,
   output logic              done
);
   state_t              state_q, state_d;
   logic [OPW-1:0]      op_q;
   logic [REG_AW-1:0]   ra1_q, ra2_q, wa_q;
   logic [ALUW-1:0]     alu_op_q;
   logic [4:0]          psr_q;
   logic [ALUW-1:0]     dec_alu_op;
   logic                dec_writes_rd;
   logic [4:0]          dec_mask;
   logic                dec_illegal;
   logic                idle, host_go, accept;
   logic [4:0]          flags;

   op_decode #(.OPW(OPW), .ALUW(ALUW)) u_dec (
      .op_i        (op_q),
      .alu_op_o    (dec_alu_op),
      .writes_rd_o (dec_writes_rd),
      .flag_mask_o (dec_mask),
      .illegal_o   (dec_illegal)
   );

   assign idle        = state_q == S_IDLE;
   assign host_go     = idle & host_we;
   assign accept      = idle & instr_valid & ~host_we;
   assign flags       = {alu_n, alu_z, alu_f, alu_l, alu_c};
   assign instr_ready = idle & ~host_we;
   assign host_grant  = host_go;
   assign wd_sel      = host_go;
   assign regwrite    = host_go | (state_q == S_WB && dec_writes_rd);
   assign wa          = host_go ? host_wa : wa_q;
   assign ra1         = ra1_q;
   assign ra2         = ra2_q;
   assign alu_op      = alu_op_q;
   assign psr         = psr_q;
   assign busy        = ~idle;

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      case (state_q)
         S_IDLE: state_d = accept ? S_READ : S_IDLE;
         S_READ: state_d = S_EXEC;
         S_EXEC: begin
`ifdef CMP_SKIP_WB_EN
            // non-writing opcodes (CMP, illegal) have nothing to do in WB
            state_d = dec_writes_rd ? S_WB : S_IDLE;
            done    = ~dec_writes_rd;
`else
            state_d = S_WB;
`endif
         end
         S_WB: begin
            state_d = S_IDLE;
            done    = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         ra1_q    <= '0;
         ra2_q    <= '0;
         wa_q     <= '0;
         alu_op_q <= '0;
         psr_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q  <= instr_op;
            ra1_q <= instr_rdest;
            ra2_q <= instr_rsrc;
         end
         // wa keeps the last address actually presented, host or writeback
         if (host_go) wa_q <= host_wa;
         if (state_q == S_READ) alu_op_q <= dec_alu_op;
         if (state_q == S_EXEC) begin
            if (!dec_illegal) psr_q <= (psr_q & ~dec_mask) | (flags & dec_mask);
            if (dec_writes_rd) wa_q <= ra1_q;
         end
      end
   end
endmodule
